// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide controller: radix-2 Booth multiply and
// restoring divide on magnitudes, WIDTH iterations each, results to HI/LO.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] MULT   = 3'd1;
  localparam logic [2:0] DIV    = 3'd2;
  localparam logic [2:0] FINISH = 3'd3;
  localparam logic [2:0] EXC    = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    count;
  logic             opReg;
  logic [WIDTH-1:0] multiplicand;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisorMag;
  logic             negQuo;
  logic             negRem;

  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH:0]   extA;
  logic [WIDTH:0]   accTop;
  logic [WIDTH:0]   boothSum;
  logic [2*WIDTH:0] accNext;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] divHi;
  logic [WIDTH-1:0] divLo;

  assign busy = (state != IDLE);

  // Magnitude of the most negative value stays representable as unsigned.
  assign magA = src_a[WIDTH-1] ? -src_a : src_a;
  assign magB = src_b[WIDTH-1] ? -src_b : src_b;

  // Booth add is done one bit wider so the most negative multiplicand
  // cannot overflow before the arithmetic shift.
  always_comb begin
    extA   = {multiplicand[WIDTH-1], multiplicand};
    accTop = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   boothSum = accTop + extA;
      2'b10:   boothSum = accTop - extA;
      default: boothSum = accTop;
    endcase
    accNext = {boothSum, acc[WIDTH:1]};
  end

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisorMag};
    if (!diff[WIDTH]) begin
      remNext = diff[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end else begin
      remNext = shifted[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign divLo = negQuo ? -quo : quo;
  assign divHi = negRem ? -rem : rem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      opReg        <= 1'b0;
      multiplicand <= '0;
      acc          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisorMag   <= '0;
      negQuo       <= 1'b0;
      negRem       <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
      done         <= 1'b0;
      div0         <= 1'b0;
      hi_write     <= 1'b0;
      lo_write     <= 1'b0;
    end else begin
      done     <= 1'b0;
      div0     <= 1'b0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opReg        <= op;
            count        <= '0;
            multiplicand <= src_a;
            acc          <= {{WIDTH{1'b0}}, src_b, 1'b0};
            rem          <= '0;
            quo          <= magA;
            divisorMag   <= magB;
            negQuo       <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            negRem       <= src_a[WIDTH-1];
            if (!op)
              state <= MULT;
            else if (src_b == '0)
              state <= EXC;
            else
              state <= DIV;
          end
        end
        MULT: begin
          acc   <= accNext;
          count <= count + CW'(1);
          if (count == LAST_STEP)
            state <= FINISH;
        end
        DIV: begin
          rem   <= remNext;
          quo   <= quoNext;
          count <= count + CW'(1);
          if (count == LAST_STEP)
            state <= FINISH;
        end
        FINISH: begin
          hi_out   <= opReg ? divHi : acc[2*WIDTH:WIDTH+1];
          lo_out   <= opReg ? divLo : acc[WIDTH:1];
          done     <= 1'b1;
          hi_write <= 1'b1;
          lo_write <= 1'b1;
          state    <= IDLE;
        end
        EXC: begin
          div0  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed vector table, corner
// sequences (reset abort, held start, back-to-back) and randomized ops.
module tb_mult_div_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        hiWrite;
  logic        loWrite;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastDoneCyc = 0;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (srcA),
    .src_b   (srcB),
    .busy    (busy),
    .done    (done),
    .div0    (div0),
    .hi_out  (hiOut),
    .lo_out  (loOut),
    .hi_write(hiWrite),
    .lo_write(loWrite)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eHi;
    logic [31:0] eLo;
    logic        eDiv0;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic (truncating division).
  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eHi, output logic [31:0] eLo, output logic eDiv0);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eDiv0 = 1'b0;
    if (!o) begin
      p   = sa * sb;
      eHi = p[63:32];
      eLo = p[31:0];
    end else if (b == 32'd0) begin
      eDiv0 = 1'b1;
      eHi = lastHi;
      eLo = lastLo;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      eHi = r[31:0];
      eLo = q[31:0];
    end
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] corners [4];
    logic [31:0] v;
    corners[0] = 32'h8000_0000;
    corners[1] = 32'h7FFF_FFFF;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h0000_0001;
    case ($urandom_range(0, 3))
      0: v = corners[$urandom_range(0, 3)];
      1: begin
        v = 32'($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one operation; returns after the sample of the result cycle, so a
  // following call is a back-to-back start.
  task automatic runOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eHi, input logic [31:0] eLo,
                       input logic eDiv0, input bit scramble);
    int limit, busyLimit, doneK, div0K, nDone, nDiv0, badWrite, both;
    logic wrAtDone;
    logic [31:0] gotHi, gotLo;
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clock); #1;
    limit     = eDiv0 ? 3 : 33;
    busyLimit = eDiv0 ? 1 : 33;
    doneK = -1; div0K = -1; nDone = 0; nDiv0 = 0; badWrite = 0; both = 0;
    wrAtDone = 1'b0; gotHi = '0; gotLo = '0;
    for (int k = 0; k <= limit; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
        if (done) begin
          nDone++; doneK = k; wrAtDone = hiWrite & loWrite;
          gotHi = hiOut; gotLo = loOut; lastDoneCyc = cyc;
        end
        if (div0) begin nDiv0++; div0K = k; end
        if (done && div0) both++;
        if ((hiWrite || loWrite) && !done) badWrite++;
        if (k == 1 && !eDiv0) check("busy during op", 64'(busy), 64'd1);
        if (k == 2 && eDiv0) check("busy after div0", 64'(busy), 64'd0);
      end
      if (scramble && k < busyLimit) begin
        start = 1'($urandom_range(0, 1));
        op    = 1'($urandom_range(0, 1));
        srcA  = $urandom;
        srcB  = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check("done/div0 overlap", 64'(both), 64'd0);
    check("stray write", 64'(badWrite), 64'd0);
    if (!eDiv0) begin
      check("done edge", 64'(doneK), 64'd33);
      check("done count", 64'(nDone), 64'd1);
      check("div0 count", 64'(nDiv0), 64'd0);
      check("writes with done", 64'(wrAtDone), 64'd1);
      check("hi result", 64'(gotHi), 64'(eHi));
      check("lo result", 64'(gotLo), 64'(eLo));
      check("idle at done", 64'(busy), 64'd0);
      lastHi = eHi;
      lastLo = eLo;
    end else begin
      check("div0 edge", 64'(div0K), 64'd1);
      check("div0 count", 64'(nDiv0), 64'd1);
      check("no done on div0", 64'(nDone), 64'd0);
      check("hi held", 64'(hiOut), 64'(eHi));
      check("lo held", 64'(loOut), 64'(eLo));
    end
  endtask

  initial begin
    logic [31:0] ra, rb, eHi, eLo;
    logic ro, eD;
    int d1, nDone, lastK;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[6]  = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};
    vecs[7]  = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0692, 32'h0000_0020, 32'h0000_0012, 32'h0000_0034, 1'b0};
    vecs[9]  = '{1'b1, 32'd5,         32'd0,         32'h0000_0012, 32'h0000_0034, 1'b1};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};

    reset = 1'b0; start = 1'b0; op = 1'b0; srcA = '0; srcB = '0;
    #1 reset = 1'b1;
    #2;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div0", 64'(div0), 64'd0);
    check("reset writes", 64'({hiWrite, loWrite}), 64'd0);
    check("reset hi", 64'(hiOut), 64'd0);
    check("reset lo", 64'(loOut), 64'd0);
    @(negedge clock) reset = 1'b0;

    for (int i = 0; i < 11; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo, vecs[i].eDiv0, (i % 2) == 1);

    // Two back-to-back multiplies must complete 34 cycles apart.
    runOp(1'b0, 32'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 1'b0, 1'b0);
    d1 = lastDoneCyc;
    runOp(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    check("back-to-back spacing", 64'(lastDoneCyc - d1), 64'd34);

    // Reset between E10 and E11 aborts the multiply immediately.
    @(negedge clock);
    start = 1'b1; op = 1'b0; srcA = 32'd3; srcB = 32'd5;
    @(posedge clock); #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort outputs", 64'({hiOut, loOut}), 64'd0);
    check("abort flags", 64'({done, div0, hiWrite, loWrite}), 64'd0);
    @(negedge clock) reset = 1'b0;
    lastHi = '0; lastLo = '0;
    nDone = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done || hiWrite || loWrite) nDone++;
    end
    check("no done after abort", 64'(nDone), 64'd0);
    runOp(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

    // start held high: one done per accepted start, every 34 cycles.
    start = 1'b1; op = 1'b0; srcA = 32'hFFFF_FFFF; srcB = 32'd9;
    @(posedge clock); #1;
    nDone = 0; lastK = -1;
    for (int k = 1; k <= 101; k++) begin
      @(posedge clock); #1;
      if (done) begin
        nDone++; lastK = k;
        check("held-start hi", 64'(hiOut), 64'hFFFF_FFFF);
        check("held-start lo", 64'(loOut), 64'hFFFF_FFF7);
      end
    end
    start = 1'b0;
    check("held-start done count", 64'(nDone), 64'd3);
    check("held-start last done", 64'(lastK), 64'd101);
    lastHi = 32'hFFFF_FFFF; lastLo = 32'hFFFF_FFF7;

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = randOperand();
      rb = randOperand();
      if (ro && $urandom_range(0, 7) == 0) rb = '0;
      model(ro, ra, rb, eHi, eLo, eD);
      runOp(ro, ra, rb, eHi, eLo, eD, (i % 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
